// File: rtl/uart_frame_pkg.sv
// Shared constants for the 5-byte UART command frame (SYNC, ADDR, DATA_HI, DATA_LO, CSUM).
// Error codes are shared with the TX-side frame encoder.
package uart_frame_pkg;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam int         FRAME_LEN     = 5;

  typedef enum logic [2:0] {
    ST_HUNT = 3'd0,
    ST_ADDR = 3'd1,
    ST_DHI  = 3'd2,
    ST_DLO  = 3'd3,
    ST_CSUM = 3'd4,
    ST_HOLD = 3'd5
  } frame_state_t;

  typedef logic [1:0] err_code_t;
  localparam err_code_t ERR_NONE    = 2'd0;
  localparam err_code_t ERR_CSUM    = 2'd1;
  localparam err_code_t ERR_TIMEOUT = 2'd2;
  localparam err_code_t ERR_OVERRUN = 2'd3;

endpackage

// File: rtl/uart_frame_decoder.sv
// Assembles checksummed 5-byte frames into register-write commands; cmd_valid 1 cycle after CSUM.
// Command is held until cmd_ready; bytes arriving while it is held are dropped and flagged.
module uart_frame_decoder
  import uart_frame_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEF,
  parameter int         TIMEOUT_CYCLES = 100000,
  localparam int        TO_W           = $clog2(TIMEOUT_CYCLES)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [7:0]  cmd_addr,
  output logic [15:0] cmd_data,
  output logic        err_csum,
  output logic        err_timeout,
  output logic        err_overrun
);

  // Expiry fires on the idle cycle that would push the counter to TIMEOUT_CYCLES-1.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 2);

  frame_state_t    state_q, state_d;
  logic [7:0]      acc_q, acc_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [7:0]      addr_q, addr_d, dhi_q, dhi_d, dlo_q, dlo_d;
  logic            cmd_valid_d;
  logic [7:0]      cmd_addr_d;
  logic [15:0]     cmd_data_d;
  err_code_t       err_q, err_d;
  logic            in_frame;
  logic            sync_hit;

  assign sync_hit = rx_valid && (rx_data == SYNC_BYTE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_HUNT;
      acc_q     <= '0;
      cnt_q     <= '0;
      addr_q    <= '0;
      dhi_q     <= '0;
      dlo_q     <= '0;
      cmd_valid <= 1'b0;
      cmd_addr  <= '0;
      cmd_data  <= '0;
      err_q     <= ERR_NONE;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      dhi_q     <= dhi_d;
      dlo_q     <= dlo_d;
      cmd_valid <= cmd_valid_d;
      cmd_addr  <= cmd_addr_d;
      cmd_data  <= cmd_data_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    dhi_d       = dhi_q;
    dlo_d       = dlo_q;
    cmd_valid_d = cmd_valid;
    cmd_addr_d  = cmd_addr;
    cmd_data_d  = cmd_data;
    err_d       = ERR_NONE;
    in_frame    = (state_q == ST_ADDR) || (state_q == ST_DHI) ||
                  (state_q == ST_DLO)  || (state_q == ST_CSUM);

    // A byte on the expiry cycle wins, so the timeout only triggers on an idle cycle.
    if (in_frame) begin
      if (rx_valid) begin
        cnt_d = '0;
      end else if (cnt_q == TO_LAST) begin
        cnt_d   = '0;
        state_d = ST_HUNT;
        err_d   = ERR_TIMEOUT;
      end else begin
        cnt_d = cnt_q + TO_W'(1);
      end
    end

    unique case (state_q)
      ST_HUNT: begin
        if (sync_hit) begin
          state_d = ST_ADDR;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      ST_ADDR: begin
        if (rx_valid) begin
          addr_d  = rx_data;
          acc_d   = acc_q + rx_data;
          state_d = ST_DHI;
        end
      end
      ST_DHI: begin
        if (rx_valid) begin
          dhi_d   = rx_data;
          acc_d   = acc_q + rx_data;
          state_d = ST_DLO;
        end
      end
      ST_DLO: begin
        if (rx_valid) begin
          dlo_d   = rx_data;
          acc_d   = acc_q + rx_data;
          state_d = ST_CSUM;
        end
      end
      ST_CSUM: begin
        if (rx_valid) begin
          if (rx_data == acc_q) begin
            cmd_valid_d = 1'b1;
            cmd_addr_d  = addr_q;
            cmd_data_d  = {dhi_q, dlo_q};
            state_d     = ST_HOLD;
          end else begin
            err_d   = ERR_CSUM;
            state_d = ST_HUNT;
          end
        end
      end
      ST_HOLD: begin
        // cmd_valid is always high here, so cmd_ready alone completes the handshake.
        if (cmd_ready) begin
          cmd_valid_d = 1'b0;
          if (sync_hit) begin
            state_d = ST_ADDR;
            acc_d   = '0;
            cnt_d   = '0;
          end else begin
            state_d = ST_HUNT;
          end
        end else if (rx_valid) begin
          err_d = ERR_OVERRUN;
        end
      end
      default: state_d = ST_HUNT;
    endcase
  end

  assign err_csum    = (err_q == ERR_CSUM);
  assign err_timeout = (err_q == ERR_TIMEOUT);
  assign err_overrun = (err_q == ERR_OVERRUN);

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Directed bench for uart_frame_decoder: queue-based frame model compared every cycle,
// plus literal checks at the key points of each scenario.
module tb_uart_frame_decoder;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        cmd_ready = 1'b0;
  logic        cmd_valid;
  logic [7:0]  cmd_addr;
  logic [15:0] cmd_data;
  logic        err_csum, err_timeout, err_overrun;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  uart_frame_decoder #(.SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_data(cmd_data), .err_csum(err_csum), .err_timeout(err_timeout),
    .err_overrun(err_overrun)
  );

  // Model: frame bytes collected in a queue, idle gap counted since the last byte.
  logic [7:0]  fb[$];
  int          gap = 0;
  logic        m_live = 1'b0;
  logic        e_valid = 1'b0, e_csum = 1'b0, e_to = 1'b0, e_ovr = 1'b0;
  logic [7:0]  e_addr = 8'h00;
  logic [15:0] e_data = 16'h0000;

  always @(posedge clk) begin
    logic [9:0] sum;
    e_csum = 1'b0;
    e_to   = 1'b0;
    e_ovr  = 1'b0;
    if (rst) begin
      fb.delete();
      gap = 0;
      e_valid = 1'b0;
      e_addr = 8'h00;
      e_data = 16'h0000;
    end else if (e_valid) begin
      if (cmd_ready) begin
        e_valid = 1'b0;
        if (rx_valid && rx_data == 8'hA5) begin
          fb.push_back(rx_data);
          gap = 0;
        end
      end else if (rx_valid) begin
        e_ovr = 1'b1;
      end
    end else if (fb.size() == 0) begin
      if (rx_valid && rx_data == 8'hA5) begin
        fb.push_back(rx_data);
        gap = 0;
      end
    end else if (rx_valid) begin
      fb.push_back(rx_data);
      gap = 0;
      if (fb.size() == 5) begin
        sum = 10'(fb[1]) + 10'(fb[2]) + 10'(fb[3]);
        if (sum[7:0] == fb[4]) begin
          e_valid = 1'b1;
          e_addr  = fb[1];
          e_data  = {fb[2], fb[3]};
        end else begin
          e_csum = 1'b1;
        end
        fb.delete();
      end
    end else begin
      gap++;
      if (gap >= TO - 1) begin
        e_to = 1'b1;
        fb.delete();
      end
    end
    m_live = 1'b1;
  end

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (m_live) begin
      chk("cmp_cmd_valid", 16'(cmd_valid), 16'(e_valid));
      chk("cmp_cmd_addr", 16'(cmd_addr), 16'(e_addr));
      chk("cmp_cmd_data", cmd_data, e_data);
      chk("cmp_err_csum", 16'(err_csum), 16'(e_csum));
      chk("cmp_err_timeout", 16'(err_timeout), 16'(e_to));
      chk("cmp_err_overrun", 16'(err_overrun), 16'(e_ovr));
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input int g);
    idle(g);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic frame(input logic [7:0] b0, b1, b2, b3, b4, input int g);
    send(b0, g);
    send(b1, g);
    send(b2, g);
    send(b3, g);
    send(b4, g);
  endtask

  initial begin
    idle(3);
    chk("rst_cmd_valid", 16'(cmd_valid), 16'h0);
    chk("rst_cmd_addr", 16'(cmd_addr), 16'h0);
    chk("rst_cmd_data", cmd_data, 16'h0);
    chk("rst_errs", 16'({err_csum, err_timeout, err_overrun}), 16'h0);
    rst = 1'b0;
    cmd_ready = 1'b1;
    idle(2);

    // Good frame, 3-cycle gaps
    frame(8'hA5, 8'h12, 8'h34, 8'h56, 8'h9C, 3);
    chk("good_valid", 16'(cmd_valid), 16'h1);
    chk("good_addr", 16'(cmd_addr), 16'h0012);
    chk("good_data", cmd_data, 16'h3456);
    idle(1);
    chk("good_valid_drop", 16'(cmd_valid), 16'h0);

    // Bad checksum, then a carry-dropping good frame
    frame(8'hA5, 8'h12, 8'h34, 8'h56, 8'h9D, 1);
    chk("csum_err", 16'(err_csum), 16'h1);
    chk("csum_no_valid", 16'(cmd_valid), 16'h0);
    chk("csum_addr_kept", 16'(cmd_addr), 16'h0012);
    idle(2);
    frame(8'hA5, 8'h01, 8'h00, 8'hFF, 8'h00, 0);
    chk("wrap1_addr", 16'(cmd_addr), 16'h0001);
    chk("wrap1_data", cmd_data, 16'h00FF);
    idle(2);

    // SYNC value as payload, checksum wrap
    frame(8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hEF, 2);
    chk("sync_data_addr", 16'(cmd_addr), 16'h00A5);
    chk("sync_data_data", cmd_data, 16'hA5A5);
    idle(2);

    // Timeout after 15 idle cycles
    send(8'hA5, 0);
    send(8'h12, 0);
    idle(14);
    chk("to_not_yet", 16'(err_timeout), 16'h0);
    idle(1);
    chk("to_fired", 16'(err_timeout), 16'h1);
    idle(1);
    frame(8'hA5, 8'h20, 8'h00, 8'h01, 8'h21, 1);
    chk("to_next_valid", 16'(cmd_valid), 16'h1);
    chk("to_next_data", cmd_data, 16'h0001);
    idle(2);

    // 14-cycle gaps never time out (byte on expiry cycle wins)
    send(8'hA5, 0);
    send(8'h12, 14);
    send(8'h34, 14);
    send(8'h56, 14);
    send(8'h9C, 14);
    chk("gap14_valid", 16'(cmd_valid), 16'h1);
    chk("gap14_addr", 16'(cmd_addr), 16'h0012);
    idle(2);

    // Backpressure / overrun
    cmd_ready = 1'b0;
    frame(8'hA5, 8'h12, 8'h34, 8'h56, 8'h9C, 1);
    idle(2);
    send(8'h77, 0);
    chk("ovr_err", 16'(err_overrun), 16'h1);
    chk("ovr_valid_held", 16'(cmd_valid), 16'h1);
    chk("ovr_data_held", cmd_data, 16'h3456);
    idle(1);
    rx_valid  = 1'b1;
    rx_data   = 8'hA5;
    cmd_ready = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    chk("hs_valid_drop", 16'(cmd_valid), 16'h0);
    chk("hs_no_ovr", 16'(err_overrun), 16'h0);
    send(8'h00, 0);
    send(8'h00, 0);
    send(8'h00, 0);
    send(8'h00, 0);
    chk("hs_frame_valid", 16'(cmd_valid), 16'h1);
    chk("hs_frame_data", cmd_data, 16'h0000);
    idle(2);

    // Reset mid-frame
    send(8'hA5, 0);
    send(8'h12, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    send(8'h34, 0);
    send(8'h56, 0);
    send(8'h9C, 0);
    idle(2);
    chk("rstmid_no_valid", 16'(cmd_valid), 16'h0);
    chk("rstmid_addr", 16'(cmd_addr), 16'h0000);
    frame(8'hA5, 8'h12, 8'h34, 8'h56, 8'h9C, 1);
    chk("rstmid_good", 16'(cmd_valid), 16'h1);
    chk("rstmid_good_data", cmd_data, 16'h3456);
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
